// File: rtl/data_cal_acc.sv
// Window reducer for the data_cal result stream: accumulates 2^LOG2N valid
// samples into sum/avg/max/min and offers each window result on a ready/valid port.
module data_cal_acc #(
   parameter int LOG2N = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         din,
   input  logic               din_valid,
   input  logic               clr,
   input  logic               res_ready,
   output logic               res_valid,
   output logic [4+LOG2N:0]   res_sum,
   output logic [4:0]         res_avg,
   output logic [4:0]         res_max,
   output logic [4:0]         res_min,
   output logic               overrun,
   output logic [LOG2N-1:0]   fill_cnt
);

   localparam int AW = 5 + LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;

   logic [LOG2N-1:0] fill_q, fill_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [4:0]       max_q, max_d;
   logic [4:0]       min_q, min_d;
   logic             rvalid_q, rvalid_d;
   logic [AW-1:0]    rsum_q, rsum_d;
   logic [4:0]       rmax_q, rmax_d;
   logic [4:0]       rmin_q, rmin_d;
   logic             ovr_q, ovr_d;

   logic             take, done, first, xfer;
   logic [AW-1:0]    acc_sum;
   logic [4:0]       smax, smin;

   always_comb begin
      take    = din_valid && !clr;
      done    = take && (fill_q == LAST);
      first   = (fill_q == '0);
      xfer    = rvalid_q && res_ready;
      acc_sum = acc_q + AW'(din);
      // An empty window seeds max/min from the sample instead of comparing to stale state
      smax    = (first || din > max_q) ? din : max_q;
      smin    = (first || din < min_q) ? din : min_q;

      fill_d   = fill_q;
      acc_d    = acc_q;
      max_d    = max_q;
      min_d    = min_q;
      rvalid_d = rvalid_q;
      rsum_d   = rsum_q;
      rmax_d   = rmax_q;
      rmin_d   = rmin_q;
      ovr_d    = ovr_q;

      if (clr) begin
         fill_d = '0;
         acc_d  = '0;
         max_d  = '0;
         min_d  = '0;
         ovr_d  = 1'b0;
      end else if (take) begin
         if (done) begin
            fill_d = '0;
            acc_d  = '0;
            max_d  = '0;
            min_d  = '0;
         end else begin
            fill_d = fill_q + LOG2N'(1);
            acc_d  = acc_sum;
            max_d  = smax;
            min_d  = smin;
         end
      end

      if (xfer)
         rvalid_d = 1'b0;

      // A finished window replaces the result only if the slot is free or being emptied now
      if (done) begin
         if (!rvalid_q || res_ready) begin
            rvalid_d = 1'b1;
            rsum_d   = acc_sum;
            rmax_d   = smax;
            rmin_d   = smin;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q   <= '0;
         acc_q    <= '0;
         max_q    <= '0;
         min_q    <= '0;
         rvalid_q <= 1'b0;
         rsum_q   <= '0;
         rmax_q   <= '0;
         rmin_q   <= '0;
         ovr_q    <= 1'b0;
      end else begin
         fill_q   <= fill_d;
         acc_q    <= acc_d;
         max_q    <= max_d;
         min_q    <= min_d;
         rvalid_q <= rvalid_d;
         rsum_q   <= rsum_d;
         rmax_q   <= rmax_d;
         rmin_q   <= rmin_d;
         ovr_q    <= ovr_d;
      end
   end

   assign res_valid = rvalid_q;
   assign res_sum   = rsum_q;
   assign res_avg   = rsum_q[AW-1:LOG2N];
   assign res_max   = rmax_q;
   assign res_min   = rmin_q;
   assign overrun   = ovr_q;
   assign fill_cnt  = fill_q;

endmodule

// File: doc/data_cal_acc.md
Name: data_cal_acc

Overview:
- Downstream consumer of the data_cal stage: takes its 5-bit result stream (out/validout) and reduces each window of 2^LOG2N valid samples to sum, average, max and min.
- Presents each window result on a ready/valid output port.
- Holds a result until it is accepted and flags overrun when a completed window cannot be delivered.

Parameters:
LOG2N, 2, log2 of samples per window; legal range 1..4 (N = 2^LOG2N)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  5  sample value (data_cal out), full range 0..31 accepted
din_valid  input  1  sample qualifier (data_cal validout)
clr  input  1  synchronous clear: abandon partial window, clear overrun
res_ready  input  1  downstream accepts result when high with res_valid
res_valid  output  1  result registers hold an unaccepted result
res_sum  output  5+LOG2N  sum of the N window samples
res_avg  output  5  res_sum >> LOG2N (truncating)
res_max  output  5  largest sample in window
res_min  output  5  smallest sample in window
overrun  output  1  sticky: a completed window was dropped
fill_cnt  output  LOG2N  samples taken so far in current window

Behaviour:
- Reset (rst=1 at edge): res_valid, res_sum, res_avg, res_max, res_min, overrun, fill_cnt, accumulator, running max/min all 0. Applies mid-window and with a result pending; the partial window and pending result are lost.
- Window state: counter fill_cnt 0..N-1. fill_cnt==0 means empty; running max/min are loaded directly from the first sample, not compared against stale values.
- Sample edge (din_valid=1, clr=0): acc += din; max = max(max,din); min = min(min,din); fill_cnt++.
- Completion edge: din_valid=1 and fill_cnt==N-1.
  - The final sample is included in the result.
  - Accumulator, fill_cnt and running max/min return to the empty state at the same edge.
  - The next sample may arrive on the following cycle: no bubble.
- Latency: res_valid rises in the cycle after the completion edge; result fields are valid whenever res_valid=1.
- Arithmetic: acc width 5+LOG2N, so no overflow at N×31. res_avg is acc_final[LOG2N+4:LOG2N].
- Handshake: transfer occurs at an edge with res_valid=1 and res_ready=1.
  - Result fields stay stable while res_valid=1 and not transferred.
  - res_ready is ignored when res_valid=0.
- Completion edge with res_valid=0, or with a transfer at the same edge: load new result, res_valid=1. Back-to-back windows with ready held high give continuous delivery.
- Completion edge with res_valid=1 and res_ready=0: new result discarded, old result held, overrun set to 1.
- overrun cleared only by rst or clr.
- clr=1 at edge:
  - Empties the partial window (acc, fill_cnt, max/min) and clears overrun.
  - A pending result and its res_valid are unaffected; a transfer on that edge still completes.
  - clr wins over a simultaneous din_valid: that sample is discarded and no completion occurs.
- din is ignored when din_valid=0. Gaps between samples do not affect the window.
- No combinational path from inputs to outputs; all outputs registered.

Test Plan:
1. LOG2N=2, rst then samples 3,5,7,9 on consecutive cycles, res_ready=1 -> res_valid high exactly one cycle after 4th sample edge, res_sum=24, res_avg=6, res_max=9, res_min=3; res_valid low next cycle; fill_cnt back to 0.
2. Samples 30,0, three idle cycles, 1,31 -> res_sum=62, res_avg=15, res_max=31, res_min=0; fill_cnt reads 2 during the idle gap.
3. res_ready=0, windows (1,1,1,1) then (2,2,2,2) -> result held at sum=4/avg=1 after second completion, overrun=1; then res_ready=1 -> res_valid drops after one edge, overrun stays 1 until clr pulse.
4. Eight consecutive samples of 10, res_ready=0 until the second completion cycle, then 1 -> first result (sum 40) transferred and second (sum 40) loaded at the same edge, res_valid continuously 1, overrun=0.
5. Samples 5,5 then clr, then 4,4,4,4 -> res_sum=16, res_min=4, res_max=4; clr asserted with din_valid=1 -> that sample absent from the sum.
6. Samples 9,9,9 then rst pulse, then 2,2,2,2 -> res_sum=8. Separately, rst while res_valid=1 and res_ready=0 -> all outputs 0 on the next cycle.
